// File: rtl/instr_mem_loader.sv
// Byte-serial loader for the 128-byte big-endian instruction memory, plus the fetch read port.
// Latency: 5 cycles per word (1 accept + 4 byte writes); load_done is high in the cycle after the last byte.
// Backpressure: wr_ready is decoded from state only, so it is high in WAIT_WORD and low otherwise.
module instr_mem_loader #(
  parameter int MEM_BYTES = 128,
  parameter int ADDR_W    = 7,
  parameter int LEN_W     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              wr_valid,
  input  logic [31:0]       wr_data,
  output logic              wr_ready,
  output logic              busy,
  output logic              load_done,
  output logic [LEN_W-1:0]  words_loaded,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  typedef enum logic [1:0] {IDLE, WAIT_WORD, WRITE, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_ptr;
  logic [LEN_W-1:0]  len_reg;
  logic [31:0]       hold_reg;
  logic [1:0]        byte_idx;
  logic [7:0]        wr_byte;
  logic [LEN_W:0]    len_eff;
  logic              last_word;
  logic              word_acc;
  logic              byte_wr;
  logic [7:0]        mem [MEM_BYTES];

  // A zero length field stands for the full 2**LEN_W words.
  assign len_eff   = (len_reg == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_reg};
  assign last_word = (({1'b0, words_loaded} + (LEN_W+1)'(1)) == len_eff);
  assign word_acc  = (state == WAIT_WORD) && wr_valid;
  assign byte_wr   = (state == WRITE);

  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    busy      = 1'b1;
    load_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (load_start) state_nxt = WAIT_WORD;
      end
      WAIT_WORD: begin
        wr_ready = 1'b1;
        if (wr_valid) state_nxt = WRITE;
      end
      WRITE: begin
        if (byte_idx == 2'd3) state_nxt = last_word ? DONE : WAIT_WORD;
      end
      DONE: begin
        load_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr_ptr     <= '0;
      len_reg      <= '0;
      hold_reg     <= '0;
      byte_idx     <= '0;
      words_loaded <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && load_start) begin
        addr_ptr     <= load_base;
        len_reg      <= load_len;
        words_loaded <= '0;
      end
      if (word_acc) begin
        hold_reg <= wr_data;
        byte_idx <= '0;
      end
      if (byte_wr) begin
        addr_ptr <= addr_ptr + ADDR_W'(1);
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) words_loaded <= words_loaded + LEN_W'(1);
      end
    end
  end

  always_comb begin
    wr_byte = hold_reg[31:24];
    case (byte_idx)
      2'd1:    wr_byte = hold_reg[23:16];
      2'd2:    wr_byte = hold_reg[15:8];
      2'd3:    wr_byte = hold_reg[7:0];
      default: wr_byte = hold_reg[31:24];
    endcase
  end

  // The array is deliberately left out of reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (byte_wr) mem[addr_ptr] <= wr_byte;
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < 4; i++) begin
      rd_data[8*(3-i) +: 8] = mem[rd_addr + ADDR_W'(i)];
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader against a byte-array memory model.
module tb_instr_mem_loader;
  localparam int MEM_BYTES = 128;
  localparam int ADDR_W    = 7;
  localparam int LEN_W     = 6;

  logic              clk;
  logic              rst_n;
  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic [LEN_W-1:0]  load_len;
  logic              wr_valid;
  logic [31:0]       wr_data;
  logic              wr_ready;
  logic              busy;
  logic              load_done;
  logic [LEN_W-1:0]  words_loaded;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;

  int checks = 0;
  int failures = 0;

  logic [7:0] ref_mem [MEM_BYTES];
  bit         known   [MEM_BYTES];
  int m_ptr, m_words, m_len, m_cyc, m_gaps, m_done_cyc;

  instr_mem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_base(load_base),
    .load_len(load_len), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .load_done(load_done), .words_loaded(words_loaded),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_word(input int a);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) w[8*(3-i) +: 8] = ref_mem[(a + i) % MEM_BYTES];
    return w;
  endfunction

  function automatic logic [31:0] ref_mask(input int a);
    logic [31:0] m = '0;
    for (int i = 0; i < 4; i++) m[8*(3-i) +: 8] = known[(a + i) % MEM_BYTES] ? 8'hFF : 8'h00;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    m_cyc++;
    @(negedge clk);
  endtask

  task automatic start_load(input int base, input int len);
    load_start = 1'b1;
    load_base  = ADDR_W'(base);
    load_len   = LEN_W'(len);
    @(posedge clk);
    @(negedge clk);
    load_start = 1'b0;
    load_base  = ADDR_W'($urandom);
    load_len   = LEN_W'($urandom);
    m_ptr = base % MEM_BYTES; m_words = 0; m_cyc = 1; m_gaps = 0; m_done_cyc = -1;
    m_len = ((len % 64) == 0) ? 64 : len;
    checks++;
    if (busy !== 1'b1 || wr_ready !== 1'b1 || load_done !== 1'b0 || words_loaded !== '0) begin
      failures++;
      $display("FAIL start busy=%b ready=%b done=%b words=%0d, want 1 1 0 0", busy, wr_ready, load_done, words_loaded);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input int nbytes, input bit hold, input bit poke);
    logic [31:0] m;
    for (int g = 0; g < gap; g++) begin
      wr_valid = 1'b0; wr_data = $urandom;
      checks++;
      if (wr_ready !== 1'b1 || busy !== 1'b1) begin
        failures++;
        $display("FAIL wait_ready ready=%b busy=%b, want 1 1", wr_ready, busy);
      end
      tick(); m_gaps++;
    end
    wr_valid = 1'b1; wr_data = w; rd_addr = ADDR_W'(m_ptr);
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_ready ready=%b, want 1", wr_ready);
    end
    tick();
    if (!hold) wr_valid = 1'b0;
    wr_data = $urandom;
    for (int k = 0; k < nbytes; k++) begin
      checks++;
      if (wr_ready !== 1'b0 || busy !== 1'b1 || load_done !== 1'b0) begin
        failures++;
        $display("FAIL write_phase ready=%b busy=%b done=%b, want 0 1 0", wr_ready, busy, load_done);
      end
      if (poke) begin
        load_start = 1'b1; load_base = ADDR_W'($urandom); load_len = LEN_W'($urandom);
      end
      tick();
      load_start = 1'b0;
      ref_mem[m_ptr] = w[8*(3-k) +: 8];
      known[m_ptr] = 1'b1;
      m_ptr = (m_ptr + 1) % MEM_BYTES;
      #1;
      m = ref_mask(int'(rd_addr));
      checks++;
      if ((rd_data & m) !== (ref_word(int'(rd_addr)) & m)) begin
        failures++;
        $display("FAIL rd_during_write addr=%0h got=%h want=%h mask=%h", rd_addr, rd_data, ref_word(int'(rd_addr)), m);
      end
    end
    if (nbytes == 4) begin
      m_words++;
      if (m_words == m_len) begin
        m_done_cyc = load_done ? m_cyc : -1;
        checks++;
        if (load_done !== 1'b1 || busy !== 1'b1 || wr_ready !== 1'b0 ||
            words_loaded !== LEN_W'(m_words) || m_cyc != 1 + m_gaps + 5 * m_len) begin
          failures++;
          $display("FAIL done done=%b busy=%b ready=%b words=%0d cyc=%0d, want 1 1 0 %0d %0d",
                   load_done, busy, wr_ready, words_loaded, m_cyc, LEN_W'(m_words), 1 + m_gaps + 5 * m_len);
        end
        tick();
        checks++;
        if (load_done !== 1'b0 || busy !== 1'b0 || words_loaded !== LEN_W'(m_words)) begin
          failures++;
          $display("FAIL after_done done=%b busy=%b words=%0d, want 0 0 %0d", load_done, busy, words_loaded, LEN_W'(m_words));
        end
      end else begin
        checks++;
        if (load_done !== 1'b0 || words_loaded !== LEN_W'(m_words)) begin
          failures++;
          $display("FAIL word_count done=%b words=%0d, want 0 %0d", load_done, words_loaded, m_words);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_start = 1'b0; load_base = '0; load_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_addr = '0;
    #2;
    checks++;
    if (wr_ready !== 1'b0 || busy !== 1'b0 || load_done !== 1'b0 || words_loaded !== '0) begin
      failures++;
      $display("FAIL reset_outputs ready=%b busy=%b done=%b words=%0d, want all 0", wr_ready, busy, load_done, words_loaded);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wr_valid = 1'b1; wr_data = $urandom;
    repeat (3) begin
      tick();
      checks++;
      if (wr_ready !== 1'b0 || busy !== 1'b0 || load_done !== 1'b0) begin
        failures++;
        $display("FAIL idle_ignores_valid ready=%b busy=%b done=%b, want 0 0 0", wr_ready, busy, load_done);
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_single_word();
    start_load(0, 1);
    send_word(32'h20080005, 0, 4, 1'b0, 1'b0);
    checks++;
    if (m_done_cyc != 6) begin
      failures++;
      $display("FAIL single_latency done_cycle=%0d, want 6", m_done_cyc);
    end
    rd_addr = '0; #1;
    checks++;
    if (rd_data !== 32'h20080005 || words_loaded !== LEN_W'(1)) begin
      failures++;
      $display("FAIL single_read rd=%h words=%0d, want 20080005 1", rd_data, words_loaded);
    end
  endtask

  task automatic test_wrap();
    start_load(7'h7C, 2);
    send_word(32'h11223344, $urandom_range(0, 2), 4, 1'b0, 1'b0);
    send_word(32'h55667788, $urandom_range(0, 2), 4, 1'b0, 1'b0);
    rd_addr = 7'h7C; #1;
    checks++;
    if (rd_data !== 32'h11223344) begin failures++; $display("FAIL wrap_hi rd=%h want 11223344", rd_data); end
    rd_addr = 7'h00; #1;
    checks++;
    if (rd_data !== 32'h55667788) begin failures++; $display("FAIL wrap_lo rd=%h want 55667788", rd_data); end
    rd_addr = 7'h7E; #1;
    checks++;
    if (rd_data !== 32'h33445566 || words_loaded !== LEN_W'(2)) begin
      failures++;
      $display("FAIL wrap_read rd=%h words=%0d, want 33445566 2", rd_data, words_loaded);
    end
  endtask

  task automatic test_backpressure();
    int base, len;
    base = $urandom_range(0, 127);
    len  = $urandom_range(2, 5);
    start_load(base, len);
    for (int i = 0; i < len; i++) send_word($urandom, 0, 4, 1'b1, 1'b1);
    repeat (3) begin
      checks++;
      if (wr_ready !== 1'b0 || busy !== 1'b0 || words_loaded !== LEN_W'(len)) begin
        failures++;
        $display("FAIL bp_extra_word ready=%b busy=%b words=%0d, want 0 0 %0d", wr_ready, busy, words_loaded, len);
      end
      tick();
    end
    wr_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      rd_addr = ADDR_W'(base + 4 * i); #1;
      checks++;
      if (rd_data !== ref_word(base + 4 * i)) begin
        failures++;
        $display("FAIL bp_mem addr=%0h rd=%h want=%h", rd_addr, rd_data, ref_word(base + 4 * i));
      end
    end
  endtask

  task automatic test_read_during_write();
    int base;
    logic [31:0] a, b, hi, expv;
    base = $urandom_range(0, 127);
    a = $urandom; b = ~a;
    start_load(base, 1);
    send_word(a, 0, 4, 1'b0, 1'b0);
    start_load(base, 1);
    wr_valid = 1'b1; wr_data = b; rd_addr = ADDR_W'(base);
    tick();
    wr_valid = 1'b0;
    checks++;
    if (rd_data !== a) begin failures++; $display("FAIL rdw_before rd=%h want=%h", rd_data, a); end
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      hi = 32'hFFFF_FFFF << (8 * (3 - k));
      expv = (b & hi) | (a & ~hi);
      checks++;
      if (rd_data !== expv) begin failures++; $display("FAIL rdw_byte%0d rd=%h want=%h", k, rd_data, expv); end
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      ref_mem[(base + i) % MEM_BYTES] = b[8*(3-i) +: 8];
      known[(base + i) % MEM_BYTES] = 1'b1;
    end
  endtask

  task automatic test_random_loads();
    logic [31:0] m;
    for (int n = 0; n < 3; n++) begin
      int len;
      len = $urandom_range(1, 6);
      start_load($urandom_range(0, 127), len);
      for (int i = 0; i < len; i++) send_word($urandom, $urandom_range(0, 2), 4, 1'b0, 1'b0);
    end
    for (int a = 0; a < MEM_BYTES; a++) begin
      rd_addr = ADDR_W'(a); #1;
      m = ref_mask(a);
      checks++;
      if ((rd_data & m) !== (ref_word(a) & m)) begin
        failures++;
        $display("FAIL rand_mem addr=%0h rd=%h want=%h mask=%h", a, rd_data, ref_word(a), m);
      end
    end
  endtask

  task automatic test_zero_length();
    int base;
    logic [31:0] sent [64];
    base = $urandom_range(0, 127);
    start_load(base, 0);
    for (int i = 0; i < 64; i++) begin
      sent[i] = $urandom;
      send_word(sent[i], $urandom_range(0, 1), 4, 1'b0, 1'b0);
    end
    checks++;
    if (words_loaded !== '0 || m_done_cyc < 0) begin
      failures++;
      $display("FAIL zero_len_count words=%0d done_seen=%0d, want 0 and done", words_loaded, m_done_cyc);
    end
    for (int i = 0; i < 32; i++) begin
      rd_addr = ADDR_W'(base + 4 * i); #1;
      checks++;
      if (rd_data !== sent[32 + i]) begin
        failures++;
        $display("FAIL zero_len_resident slot=%0d rd=%h want=%h", i, rd_data, sent[32 + i]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] pre, w;
    pre = $urandom;
    start_load(7'h10, 1);
    send_word(pre, 0, 4, 1'b0, 1'b0);
    start_load(7'h0C, 2);
    send_word($urandom, 0, 4, 1'b0, 1'b0);
    send_word(32'hAABBCCDD, 0, 2, 1'b0, 1'b0);
    rst_n = 1'b0; #1;
    checks++;
    if (wr_ready !== 1'b0 || busy !== 1'b0 || load_done !== 1'b0 || words_loaded !== '0) begin
      failures++;
      $display("FAIL reset_mid_write ready=%b busy=%b done=%b words=%0d, want all 0", wr_ready, busy, load_done, words_loaded);
    end
    tick(); tick();
    rst_n = 1'b1;
    rd_addr = 7'h10; #1;
    checks++;
    if (rd_data !== {16'hAABB, pre[15:0]}) begin
      failures++;
      $display("FAIL reset_mem rd=%h want=%h", rd_data, {16'hAABB, pre[15:0]});
    end
    tick();
    checks++;
    if (busy !== 1'b0 || wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%b ready=%b, want 0 0", busy, wr_ready);
    end
    w = $urandom;
    start_load(7'h10, 1);
    send_word(w, 1, 4, 1'b0, 1'b0);
    rd_addr = 7'h10; #1;
    checks++;
    if (rd_data !== w) begin failures++; $display("FAIL post_reset_load rd=%h want=%h", rd_data, w); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_wrap();
    test_backpressure();
    test_read_during_write();
    test_random_loads();
    test_zero_length();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
